// File: rtl/or1k_marocchino_div_sched.sv
// ---------------------------------------------------------------------------
// or1k_marocchino_div_sched
//
// This module shares the serial integer divider between two requesters:
// req0 is the integer pipe and req1 is the auxiliary/debug pipe.
//
// Behaviour:
//   - In IDLE, a request is arbitrated. The winner's operands, operation kind
//     and index are latched, and the winner gets a one-cycle ack.
//   - In ISSUE, the latched operation is presented to the divider until the
//     divider takes it.
//   - In BUSY, the block waits for the divider result to be written back,
//     then sends a one-cycle done pulse to the owner.
//   - A pipeline flush returns the block to IDLE from any state.
//
// Optional feature (macro OR1K_MAROCCHINO_DIV_SCHED_RR_EN):
//   - Defined: round-robin arbitration. When both requesters are valid, the
//     one that did not win last time wins. After reset, req0 wins first.
//   - Undefined: fixed priority. req0 always wins over req1.
//
// Ports:
//   cpu_clk, cpu_rst_n            clock, asynchronous active-low reset
//   pipeline_flush_i              synchronous flush
//   reqN_valid_i                  request pending (N = 0, 1)
//   reqN_a1_i, reqN_b1_i          numerator / denominator
//   reqN_signed_i                 signed division requested
//   reqN_unsigned_i               unsigned division requested
//   reqN_ack_o                    request latched (one-cycle pulse)
//   reqN_done_o                   result written back (one-cycle pulse)
//   exec_op_div_o                 issue strobe to the divider
//   exec_op_div_signed_o          latched signed kind
//   exec_op_div_unsigned_o        latched unsigned kind
//   exec_div_a1_o, exec_div_b1_o  latched operands
//   idiv_taking_op_i              divider accepted the issue
//   div_valid_i                   divider result valid
//   padv_wrbk_i                   write-back advance
//   grant_wrbk_to_div_i           write-back granted to the divider
//   div_owner_o                   index of the current owner
//   busy_o                        an operation is owned (state not IDLE)
// ---------------------------------------------------------------------------
module or1k_marocchino_div_sched #(
   parameter int OPTION_OPERAND_WIDTH = 32
) (
   input  logic                              cpu_clk,
   input  logic                              cpu_rst_n,
   input  logic                              pipeline_flush_i,
   input  logic                              req0_valid_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]   req0_a1_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]   req0_b1_i,
   input  logic                              req0_signed_i,
   input  logic                              req0_unsigned_i,
   output logic                              req0_ack_o,
   output logic                              req0_done_o,
   input  logic                              req1_valid_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]   req1_a1_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]   req1_b1_i,
   input  logic                              req1_signed_i,
   input  logic                              req1_unsigned_i,
   output logic                              req1_ack_o,
   output logic                              req1_done_o,
   output logic                              exec_op_div_o,
   output logic                              exec_op_div_signed_o,
   output logic                              exec_op_div_unsigned_o,
   output logic [OPTION_OPERAND_WIDTH-1:0]   exec_div_a1_o,
   output logic [OPTION_OPERAND_WIDTH-1:0]   exec_div_b1_o,
   input  logic                              idiv_taking_op_i,
   input  logic                              div_valid_i,
   input  logic                              padv_wrbk_i,
   input  logic                              grant_wrbk_to_div_i,
   output logic                              div_owner_o,
   output logic                              busy_o
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b001,
      ST_ISSUE = 3'b010,
      ST_BUSY  = 3'b100
   } state_t;

   state_t                            state_q, state_d;
   logic                              latch;
   logic                              win;
   logic                              wb_take;
   logic                              ack0_q, ack0_d;
   logic                              ack1_q, ack1_d;
   logic                              done0_q, done0_d;
   logic                              done1_q, done1_d;
   logic                              owner_q;
   logic                              signed_q, unsigned_q;
   logic [OPTION_OPERAND_WIDTH-1:0]   a1_q, b1_q;

   always_comb wb_take = div_valid_i & padv_wrbk_i & grant_wrbk_to_div_i;

`ifdef OR1K_MAROCCHINO_DIV_SCHED_RR_EN
   // last_owner resets to 1, so req0 wins the first contended grant.
   logic last_owner_q;

   always_comb begin
      win = req1_valid_i;
      if (req0_valid_i & req1_valid_i)
         win = ~last_owner_q;
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n)
         last_owner_q <= 1'b1;
      else if (latch)
         last_owner_q <= win;
   end
`else
   // The winner index is only used when some request is valid.
   always_comb win = ~req0_valid_i;
`endif

   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req0_valid_i | req1_valid_i) begin
               latch   = 1'b1;
               ack0_d  = ~win;
               ack1_d  = win;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (idiv_taking_op_i)
               state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (wb_take) begin
               done0_d = ~owner_q;
               done1_d = owner_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A flush overrides everything: no latch, no ack, no done.
      if (pipeline_flush_i) begin
         state_d = ST_IDLE;
         latch   = 1'b0;
         ack0_d  = 1'b0;
         ack1_d  = 1'b0;
         done0_d = 1'b0;
         done1_d = 1'b0;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q <= ST_IDLE;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
      end
   end

   // The operands are held from the IDLE latch until the next latch.
   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         a1_q       <= '0;
         b1_q       <= '0;
         signed_q   <= 1'b0;
         unsigned_q <= 1'b0;
         owner_q    <= 1'b0;
      end else if (latch) begin
         a1_q       <= win ? req1_a1_i       : req0_a1_i;
         b1_q       <= win ? req1_b1_i       : req0_b1_i;
         signed_q   <= win ? req1_signed_i   : req0_signed_i;
         unsigned_q <= win ? req1_unsigned_i : req0_unsigned_i;
         owner_q    <= win;
      end
   end

   always_comb begin
      req0_ack_o             = ack0_q;
      req1_ack_o             = ack1_q;
      req0_done_o            = done0_q;
      req1_done_o            = done1_q;
      exec_op_div_o          = (state_q == ST_ISSUE);
      exec_op_div_signed_o   = signed_q;
      exec_op_div_unsigned_o = unsigned_q;
      exec_div_a1_o          = a1_q;
      exec_div_b1_o          = b1_q;
      div_owner_o            = owner_q;
      busy_o                 = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_or1k_marocchino_div_sched.sv
// ---------------------------------------------------------------------------
// tb_or1k_marocchino_div_sched
//
// Self-checking bench for or1k_marocchino_div_sched.
//
// Stimulus processes push the expected ack and done events into a queue.
// The monitor pops and compares an entry each time the DUT pulses an ack or
// a done output.
//
// The owner sequence expected in the contention test follows the macro
// OR1K_MAROCCHINO_DIV_SCHED_RR_EN.
// ---------------------------------------------------------------------------
module tb_or1k_marocchino_div_sched;

   logic        cpu_clk;
   logic        cpu_rst_n;
   logic        pipeline_flush_i;
   logic        req0_valid_i, req1_valid_i;
   logic [31:0] req0_a1_i, req0_b1_i, req1_a1_i, req1_b1_i;
   logic        req0_signed_i, req0_unsigned_i, req1_signed_i, req1_unsigned_i;
   logic        req0_ack_o, req0_done_o, req1_ack_o, req1_done_o;
   logic        exec_op_div_o, exec_op_div_signed_o, exec_op_div_unsigned_o;
   logic [31:0] exec_div_a1_o, exec_div_b1_o;
   logic        idiv_taking_op_i, div_valid_i, padv_wrbk_i, grant_wrbk_to_div_i;
   logic        div_owner_o, busy_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        is_done;
      logic        id;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
   } exp_t;

   exp_t exp_q[$];

   or1k_marocchino_div_sched #(.OPTION_OPERAND_WIDTH(32)) dut (
      .cpu_clk                (cpu_clk),
      .cpu_rst_n              (cpu_rst_n),
      .pipeline_flush_i       (pipeline_flush_i),
      .req0_valid_i           (req0_valid_i),
      .req0_a1_i              (req0_a1_i),
      .req0_b1_i              (req0_b1_i),
      .req0_signed_i          (req0_signed_i),
      .req0_unsigned_i        (req0_unsigned_i),
      .req0_ack_o             (req0_ack_o),
      .req0_done_o            (req0_done_o),
      .req1_valid_i           (req1_valid_i),
      .req1_a1_i              (req1_a1_i),
      .req1_b1_i              (req1_b1_i),
      .req1_signed_i          (req1_signed_i),
      .req1_unsigned_i        (req1_unsigned_i),
      .req1_ack_o             (req1_ack_o),
      .req1_done_o            (req1_done_o),
      .exec_op_div_o          (exec_op_div_o),
      .exec_op_div_signed_o   (exec_op_div_signed_o),
      .exec_op_div_unsigned_o (exec_op_div_unsigned_o),
      .exec_div_a1_o          (exec_div_a1_o),
      .exec_div_b1_o          (exec_div_b1_o),
      .idiv_taking_op_i       (idiv_taking_op_i),
      .div_valid_i            (div_valid_i),
      .padv_wrbk_i            (padv_wrbk_i),
      .grant_wrbk_to_div_i    (grant_wrbk_to_div_i),
      .div_owner_o            (div_owner_o),
      .busy_o                 (busy_o)
   );

   initial begin
      cpu_clk = 1'b0;
      forever #5 cpu_clk = ~cpu_clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_ack(input logic id, input logic [31:0] a, input logic [31:0] b,
                           input logic s);
      exp_t e;
      e.is_done = 1'b0; e.id = id; e.a = a; e.b = b; e.s = s;
      exp_q.push_back(e);
   endtask

   task automatic push_done(input logic id);
      exp_t e;
      e.is_done = 1'b1; e.id = id; e.a = '0; e.b = '0; e.s = 1'b0;
      exp_q.push_back(e);
   endtask

   // Monitor: pops one expectation per ack/done pulse.
   task automatic mon_event(input logic is_done, input logic id);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_%s%0d: got=pulse want=none (t=%0t)",
                  is_done ? "done" : "ack", id, $time);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", {31'd0, is_done}, {31'd0, e.is_done});
         chk("event_id", {31'd0, id}, {31'd0, e.id});
         chk("owner", {31'd0, div_owner_o}, {31'd0, e.id});
         if (!is_done) begin
            chk("ack_a1", exec_div_a1_o, e.a);
            chk("ack_b1", exec_div_b1_o, e.b);
            chk("ack_signed", {31'd0, exec_op_div_signed_o}, {31'd0, e.s});
            chk("ack_unsigned", {31'd0, exec_op_div_unsigned_o}, {31'd0, ~e.s});
            chk("ack_issue", {31'd0, exec_op_div_o}, 32'd1);
         end else begin
            chk("done_idle", {31'd0, busy_o}, 32'd0);
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge cpu_clk);
         #1;
         if (req0_ack_o)  mon_event(1'b0, 1'b0);
         if (req1_ack_o)  mon_event(1'b0, 1'b1);
         if (req0_done_o) mon_event(1'b1, 1'b0);
         if (req1_done_o) mon_event(1'b1, 1'b1);
      end
   end

   task automatic set_req(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic s);
      if (id == 1'b0) begin
         req0_valid_i = 1'b1; req0_a1_i = a; req0_b1_i = b;
         req0_signed_i = s; req0_unsigned_i = ~s;
      end else begin
         req1_valid_i = 1'b1; req1_a1_i = a; req1_b1_i = b;
         req1_signed_i = s; req1_unsigned_i = ~s;
      end
   endtask

   task automatic req_start(input logic id, input logic [31:0] a, input logic [31:0] b,
                            input logic s);
      @(negedge cpu_clk);
      set_req(id, a, b, s);
      push_ack(id, a, b, s);
   endtask

   task automatic wait_ack(input logic id);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(posedge cpu_clk);
         #1;
         if (id ? req1_ack_o : req0_ack_o) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout%0d: got=none want=ack", id);
      end
   endtask

   // Entered at the ack sample point. The divider refuses the issue for
   // `stall` cycles and then takes it.
   task automatic issue_phase(input logic id, input int stall, input logic drop,
                              input logic [31:0] a);
      int hi_cnt;
      hi_cnt = (exec_op_div_o && exec_div_a1_o == a) ? 1 : 0;
      for (int i = 0; i < stall; i++) begin
         @(negedge cpu_clk);
         idiv_taking_op_i = 1'b0;
         @(posedge cpu_clk);
         #1;
         if (exec_op_div_o && exec_div_a1_o == a) hi_cnt++;
      end
      chk("issue_hold_cycles", hi_cnt, stall + 1);
      @(negedge cpu_clk);
      if (drop) begin
         if (id) req1_valid_i = 1'b0; else req0_valid_i = 1'b0;
      end
      idiv_taking_op_i = 1'b1;
      @(posedge cpu_clk);
      #1;
      chk("busy_after_take", {31'd0, busy_o}, 32'd1);
      chk("no_issue_in_busy", {31'd0, exec_op_div_o}, 32'd0);
      @(negedge cpu_clk);
      idiv_taking_op_i = 1'b0;
   endtask

   task automatic wb_phase(input logic id, input logic flush);
      @(negedge cpu_clk);
      div_valid_i = 1'b1; padv_wrbk_i = 1'b1; grant_wrbk_to_div_i = 1'b1;
      pipeline_flush_i = flush;
      if (!flush) push_done(id);
      @(posedge cpu_clk);
      #1;
      chk("idle_after_wb", {31'd0, busy_o}, 32'd0);
      @(negedge cpu_clk);
      div_valid_i = 1'b0; padv_wrbk_i = 1'b0; grant_wrbk_to_div_i = 1'b0;
      pipeline_flush_i = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack0"},  {31'd0, req0_ack_o}, 32'd0);
      chk({tag, "_ack1"},  {31'd0, req1_ack_o}, 32'd0);
      chk({tag, "_done0"}, {31'd0, req0_done_o}, 32'd0);
      chk({tag, "_done1"}, {31'd0, req1_done_o}, 32'd0);
      chk({tag, "_issue"}, {31'd0, exec_op_div_o}, 32'd0);
      chk({tag, "_sgn"},   {31'd0, exec_op_div_signed_o}, 32'd0);
      chk({tag, "_usgn"},  {31'd0, exec_op_div_unsigned_o}, 32'd0);
      chk({tag, "_a1"},    exec_div_a1_o, 32'd0);
      chk({tag, "_b1"},    exec_div_b1_o, 32'd0);
      chk({tag, "_owner"}, {31'd0, div_owner_o}, 32'd0);
      chk({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic win;
      cpu_rst_n = 1'b0; pipeline_flush_i = 1'b0;
      req0_valid_i = 1'b0; req0_a1_i = '0; req0_b1_i = '0;
      req0_signed_i = 1'b0; req0_unsigned_i = 1'b0;
      req1_valid_i = 1'b0; req1_a1_i = '0; req1_b1_i = '0;
      req1_signed_i = 1'b0; req1_unsigned_i = 1'b0;
      idiv_taking_op_i = 1'b0; div_valid_i = 1'b0;
      padv_wrbk_i = 1'b0; grant_wrbk_to_div_i = 1'b0;
      repeat (2) @(negedge cpu_clk);
      chk_all_zero("reset");
      cpu_rst_n = 1'b1;

      // Single req0 with an idle divider.
      req_start(1'b0, 32'd100, 32'd7, 1'b1);
      wait_ack(1'b0);
      issue_phase(1'b0, 0, 1'b1, 32'd100);
      wb_phase(1'b0, 1'b0);

      // Divider stalls for 5 cycles; partial write-back conditions are ignored.
      req_start(1'b0, 32'd100, 32'd9, 1'b0);
      wait_ack(1'b0);
      issue_phase(1'b0, 5, 1'b1, 32'd100);
      @(negedge cpu_clk);
      div_valid_i = 1'b1; padv_wrbk_i = 1'b1; grant_wrbk_to_div_i = 1'b0;
      @(posedge cpu_clk); #1;
      chk("no_wb_without_grant", {31'd0, busy_o}, 32'd1);
      @(negedge cpu_clk);
      padv_wrbk_i = 1'b0; grant_wrbk_to_div_i = 1'b1;
      @(posedge cpu_clk); #1;
      chk("no_wb_without_padv", {31'd0, busy_o}, 32'd1);
      @(negedge cpu_clk);
      div_valid_i = 1'b0; grant_wrbk_to_div_i = 1'b0;
      wb_phase(1'b0, 1'b0);

      // Flush in BUSY before write-back; then req1 is served.
      req_start(1'b0, 32'd42, 32'd6, 1'b1);
      wait_ack(1'b0);
      issue_phase(1'b0, 0, 1'b1, 32'd42);
      @(negedge cpu_clk);
      pipeline_flush_i = 1'b1;
      @(posedge cpu_clk); #1;
      chk("flush_busy_idle", {31'd0, busy_o}, 32'd0);
      @(negedge cpu_clk);
      pipeline_flush_i = 1'b0;
      req_start(1'b1, 32'd900, 32'd30, 1'b0);
      wait_ack(1'b1);
      issue_phase(1'b1, 0, 1'b1, 32'd900);
      wb_phase(1'b1, 1'b0);

      // Flush coincident with the write-back: no done.
      req_start(1'b0, 32'd77, 32'd11, 1'b1);
      wait_ack(1'b0);
      issue_phase(1'b0, 0, 1'b1, 32'd77);
      wb_phase(1'b0, 1'b1);

      // Flush coincident with the IDLE latch: nothing latched.
      @(negedge cpu_clk);
      set_req(1'b0, 32'd555, 32'd5, 1'b0);
      pipeline_flush_i = 1'b1;
      @(posedge cpu_clk); #1;
      chk("flush_latch_busy", {31'd0, busy_o}, 32'd0);
      chk("flush_latch_a1", exec_div_a1_o, 32'd77);
      chk("flush_latch_ack0", {31'd0, req0_ack_o}, 32'd0);
      @(negedge cpu_clk);
      pipeline_flush_i = 1'b0;
      push_ack(1'b0, 32'd555, 32'd5, 1'b0);
      wait_ack(1'b0);
      issue_phase(1'b0, 0, 1'b1, 32'd555);
      wb_phase(1'b0, 1'b0);

      // Asynchronous reset while BUSY.
      req_start(1'b1, 32'd321, 32'd3, 1'b1);
      wait_ack(1'b1);
      issue_phase(1'b1, 0, 1'b1, 32'd321);
      @(posedge cpu_clk);
      #3;
      cpu_rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(negedge cpu_clk);
      cpu_rst_n = 1'b1;

      // Both requesters valid continuously for 4 operations.
      @(negedge cpu_clk);
      set_req(1'b0, 32'd1000, 32'd10, 1'b1);
      set_req(1'b1, 32'd2000, 32'd20, 1'b0);
      for (int k = 0; k < 4; k++) begin
`ifdef OR1K_MAROCCHINO_DIV_SCHED_RR_EN
         win = (k % 2 == 1);
`else
         win = 1'b0;
`endif
         if (win) push_ack(1'b1, 32'd2000, 32'd20, 1'b0);
         else     push_ack(1'b0, 32'd1000, 32'd10, 1'b1);
         wait_ack(win);
         issue_phase(win, 0, 1'b0, win ? 32'd2000 : 32'd1000);
         wb_phase(win, 1'b0);
         if (k == 3) begin
            req0_valid_i = 1'b0;
            req1_valid_i = 1'b0;
         end
      end

      repeat (5) @(negedge cpu_clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/or1k_marocchino_div_sched.md
# or1k_marocchino_div_sched

Two-port scheduler that shares the serial integer divider between two requesters (req0: integer pipe, req1: auxiliary/debug pipe). It arbitrates requests, latches the winner's operands, presents them to the divider issue port and holds them until the divider takes the operation. It then tracks ownership until the divider result is written back and returns a per-requester completion pulse. It sits between the reservation stations and the divider, and is flushed together with the pipeline.

## Interface
- OPTION_OPERAND_WIDTH, 32, operand/result width (DW)
- cpu_clk  in  1  clock, all state on rising edge
- cpu_rst_n  in  1  asynchronous active-low reset
- pipeline_flush_i  in  1  synchronous flush, aborts everything
- reqN_valid_i (N=0,1)  in  1  request pending; held until reqN_ack_o seen
- reqN_a1_i, reqN_b1_i  in  DW  numerator / denominator
- reqN_signed_i, reqN_unsigned_i  in  1  operation kind (one-hot when valid)
- reqN_ack_o  out  1  one-cycle pulse: request latched
- reqN_done_o  out  1  one-cycle pulse: result of this requester written back
- exec_op_div_o  out  1  issue strobe to divider
- exec_op_div_signed_o, exec_op_div_unsigned_o  out  1  latched kind
- exec_div_a1_o, exec_div_b1_o  out  DW  latched operands
- idiv_taking_op_i  in  1  divider accepted issue
- div_valid_i  in  1  divider result valid
- padv_wrbk_i, grant_wrbk_to_div_i  in  1  write-back advance / grant
- div_owner_o  out  1  index of current owner (valid when busy_o)
- busy_o  out  1  state != IDLE

## Operation
- FSM, one-hot: IDLE, ISSUE, BUSY.
- IDLE: if any reqN_valid_i, winner chosen (see Configuration); operands/kind latched, owner latched, reqW_ack_o=1 next cycle, -> ISSUE. No request: stay.
- ISSUE: exec_op_div_o=1 with latched data. idiv_taking_op_i=1 -> BUSY; else stay (divider still draining previous result).
- BUSY: exec_op_div_o=0. wb_take = div_valid_i & padv_wrbk_i & grant_wrbk_to_div_i; on wb_take: reqOwner_done_o=1 next cycle, -> IDLE.
- Requests arriving outside IDLE are ignored (no ack); requester keeps valid.
- Only one operation in flight; ack and done never asserted together for the same requester.
- exec_div_* outputs change only on IDLE latch; stable through ISSUE/BUSY.
- Flush (any state): -> IDLE next edge; ack/done cleared; no done for aborted operation; owner/last-owner history preserved.
- Reset values: state IDLE, all *_o control outputs 0, exec_div_a1_o/b1_o 0, div_owner_o 0, last_owner 1.

## Timing
- req valid at edge n (IDLE) -> ack high cycle n+1 -> exec_op_div_o high from cycle n+1.
- Divider idle: taking at n+1, BUSY from n+2.
- wb_take at edge m -> done high cycle m+1, IDLE from m+1; next acceptance no earlier than edge m+1, ack at m+2.
- Minimum request-to-request spacing: 3 cycles plus divider latency.
- Flush coincident with wb_take: flush wins, no done.
- Flush coincident with IDLE latch: nothing latched, no ack.
- Reset deassertion mid-operation: block restarts in IDLE; divider is flushed by the same reset domain.

## Configuration
- OR1K_MAROCCHINO_DIV_SCHED_RR_EN defined: round-robin. With both requests valid, winner = ~last_owner. last_owner updates on each latch. After reset req0 wins first.
- Undefined: fixed priority, req0 always wins over req1. last_owner register absent.

## Test plan
- Single req0 with a1=100, b1=7, signed, divider idle -> ack0 at n+1, exec_op_div_o held until taking; after wb_take, done0 pulse, req1 outputs stay 0.
- Divider busy (idiv_taking_op_i low 5 cycles) -> ISSUE holds, exec_div_a1_o=100 stable, exec_op_div_o high 5+1 cycles, single ack.
- Both valid every cycle for 4 operations, RR_EN defined -> owners 0,1,0,1; undefined -> 0,0,0,0 with req1 never acked.
- Flush in BUSY before wb_take -> IDLE next cycle, no done0, busy_o=0; new req1 accepted afterwards.
- Flush same cycle as wb_take -> no done pulse; flush same cycle as IDLE latch -> no ack.
- Assert cpu_rst_n=0 asynchronously in BUSY -> all outputs 0 immediately, state IDLE, first RR grant after release goes to req0.
